// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [WIDTH-1:0] out;
  logic             bout;
  logic             busy;
  logic             done;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, data_a, data_b,
    input  out, bout, busy, done, ovf
  );

  modport slave (
    input  start, data_a, data_b,
    output out, bout, busy, done, ovf
  );
`else
  modport master (
    output start, data_a, data_b,
    input  out, bout, busy, done
  );

  modport slave (
    input  start, data_a, data_b,
    output out, bout, busy, done
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (data_a - data_b), LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow flag (ovf).
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned RES_W = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_d;

  logic [WIDTH-1:0] ra, ra_d;
  logic [WIDTH-1:0] rb, rb_d;
  // Holds the low WIDTH-1 difference bits; the final bit joins them when out loads.
  logic [RES_W-1:0] res, res_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             br, br_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a0, b0;
  logic             diff_bit;
  logic             borrow_next;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, a_msb_d;
  logic b_msb, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  // Single full-subtractor cell
  always_comb begin
    a0          = ra[0];
    b0          = rb[0];
    diff_bit    = a0 ^ b0 ^ br;
    borrow_next = (~a0 & b0) | (~(a0 ^ b0) & br);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    ra_d    = ra;
    rb_d    = rb;
    res_d   = res;
    cnt_d   = cnt;
    br_d    = br;
    out_d   = out_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb;
    b_msb_d = b_msb;
    ovf_d   = ovf_q;
`endif

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          ra_d    = bus.data_a;
          rb_d    = bus.data_b;
          res_d   = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = bus.data_a[WIDTH-1];
          b_msb_d = bus.data_b[WIDTH-1];
`endif
        end
      end

      SHIFT: begin
        ra_d  = {1'b0, ra[WIDTH-1:1]};
        rb_d  = {1'b0, rb[WIDTH-1:1]};
        res_d = RES_W'({diff_bit, res} >> 1);
        br_d  = borrow_next;
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          out_d   = {diff_bit, res};
          bout_d  = borrow_next;
          done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb != b_msb) && (diff_bit != a_msb);
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      out_q  <= '0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      ra     <= ra_d;
      rb     <= rb_d;
      res    <= res_d;
      cnt    <= cnt_d;
      br     <= br_d;
      out_q  <= out_d;
      bout_q <= bout_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= a_msb_d;
      b_msb  <= b_msb_d;
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign bus.out  = out_q;
  assign bus.bout = bout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
